pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 161 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Parametrised add/subtract unit split into STAGES pipeline stages, each
//   adding one WIDTH/STAGES-bit slice with the carry rippled through the
//   stage registers. Valid/ready handshake with back-pressure; all stages
//   hold (bubbles included) while the output beat is not taken.
//
//   Optional feature macro: PIPELINED_ADDER_SAT_EN
//     defined   - on signed overflow Sum saturates to max positive / min
//                 negative (chosen by A[MSB]); Overflow and CarryOut stay raw.
//     undefined - Sum is always the wrapped result.
//
// Parameters
//   WIDTH   operand/result width (must be divisible by STAGES)
//   STAGES  pipeline depth; latency is STAGES cycles
//
// Ports
//   Clk       clock, rising edge
//   Rst       asynchronous active-low reset
//   InValid   operand beat valid
//   InReady   unit accepts a beat this cycle
//   A, B      operands
//   Sub       1 = A - B, 0 = A + B
//   OutValid  result valid
//   OutReady  downstream accepts the result
//   Sum       result
//   CarryOut  carry out of the MSB (subtract: 1 = no borrow)
//   Overflow  two's-complement overflow
//   Zero      Sum == 0 (of the value actually output)
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int unsigned S = WIDTH / STAGES;

    logic             en;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    // Inputs seen by each stage: stage 0 from the ports, stage k from the
    // registers of stage k-1. Operands travel full-width alongside the
    // partially built sum.
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    assign en      = !out_valid_q || OutReady;
    assign InReady = en;

    assign a_in[0] = A;
    assign b_in[0] = Sub ? ~B : B;
    assign s_in[0] = '0;
    assign c_in[0] = Sub;
    assign v_in[0] = InValid && en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [S:0]       slice_sum;
        logic [WIDTH-1:0] sum_d;

        assign slice_sum = {1'b0, a_in[k][k*S +: S]}
                         + {1'b0, b_in[k][k*S +: S]}
                         + {{S{1'b0}}, c_in[k]};

        always_comb begin
            sum_d              = s_in[k];
            sum_d[k*S +: S]    = slice_sum[S-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (en) begin
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                    s_q <= sum_d;
                    c_q <= slice_sum[S];
                    v_q <= v_in[k];
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign s_in[k+1] = s_q;
            assign c_in[k+1] = c_q;
            assign v_in[k+1] = v_q;
        end else begin : g_last
            logic             raw_ovf;
            logic [WIDTH-1:0] res_d;

            assign raw_ovf = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1])
                          && (sum_d[WIDTH-1] != a_in[k][WIDTH-1]);

`ifdef PIPELINED_ADDER_SAT_EN
            always_comb begin
                res_d = sum_d;
                if (raw_ovf) begin
                    res_d = a_in[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign res_d = sum_d;
`endif

            // Final stage doubles as the output register; flags come from
            // the complete sum, Zero from the value actually presented.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    carry_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (en) begin
                    out_valid_q <= v_in[k];
                    sum_q       <= res_d;
                    carry_q     <= slice_sum[S];
                    ovf_q       <= raw_ovf;
                    zero_q      <= (res_d == '0);
                end
            end
        end
    end

    assign OutValid = out_valid_q;
    assign Sum      = sum_q;
    assign CarryOut = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Inputs are driven just after the falling edge and observed 1ns later;
// expected results are queued on acceptance and compared on delivery.
module tb_pipelined_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 4;

    logic          Clk;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Sub;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Sum;
    logic          CarryOut;
    logic          Overflow;
    logic          Zero;

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .Sub      (Sub),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sum      (Sum),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
        int           cyc;
        int           stalls;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   stalls   = 0;
    int   npop     = 0;
    int   hold_n   = 0;
    logic last_acc = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, sub};
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.o   = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (e.o) e.sum = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.z      = (e.sum == '0);
        e.cyc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    // One clock cycle: apply OutReady, observe, score, advance to next negedge.
    task automatic step();
        exp_t e;
        OutReady = (hold_n == 0);
        if (hold_n > 0) hold_n--;
        #1;
        check("inready", {31'b0, InReady}, {31'b0, !(OutValid && !OutReady)});
        if (OutValid && !OutReady) stalls++;
        last_acc = InValid && InReady;
        if (last_acc) begin
            e        = model(A, B, Sub);
            e.cyc    = cyc;
            e.stalls = stalls;
            q.push_back(e);
        end
        if (OutValid && OutReady) begin
            npop++;
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("sum",      Sum,                e.sum);
                check("carryout", {31'b0, CarryOut},  {31'b0, e.c});
                check("overflow", {31'b0, Overflow},  {31'b0, e.o});
                check("zero",     {31'b0, Zero},      {31'b0, e.z});
                if (e.stalls == stalls)
                    check("latency", cyc - e.cyc, ST);
            end
        end
        @(negedge Clk);
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int tries = 0;
        InValid = 1'b1;
        A       = a;
        B       = b;
        Sub     = sub;
        do begin
            step();
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) check("send_timeout", 32'd0, 32'd1);
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int p0;
        Rst      = 1'b1;
        InValid  = 1'b0;
        A        = '0;
        B        = '0;
        Sub      = 1'b0;
        OutReady = 1'b1;
        #1 Rst = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_outvalid", {31'b0, OutValid}, 32'd0);
        check("rst_sum",      Sum,               32'd0);
        check("rst_carry",    {31'b0, CarryOut}, 32'd0);
        check("rst_ovf",      {31'b0, Overflow}, 32'd0);
        check("rst_zero",     {31'b0, Zero},     32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst_inready", {31'b0, InReady}, 32'd1);
        @(negedge Clk);

        // Directed: basic add, cross-slice carry, subtract to zero,
        // signed overflow both directions, unsigned wrap.
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        send(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h1234_5678, 32'h1234_5678, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h0000_0003, 32'h0000_0005, 1'b1);
        drain();

        // Back-pressure: OutReady low for 3 cycles mid-stream.
        p0 = npop;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) hold_n = 3;
            send(W'(i), W'(i), 1'b0);
        end
        drain();
        check("bp_count", npop - p0, 32'd8);

        // Full throughput with random operands.
        c0 = cyc;
        p0 = npop;
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        check("tput_cycles", cyc - c0, 32'd100);
        check("tput_pops",   npop - p0, 32'd100 - ST);
        drain();

        // Reset while stalled with beats in flight.
        send(32'h0000_0011, 32'h0000_0022, 1'b0);
        send(32'h0000_0033, 32'h0000_0044, 1'b0);
        send(32'h0000_0055, 32'h0000_0066, 1'b0);
        hold_n = 100;
        step();
        step();
        check("pre_rst_valid", {31'b0, OutValid}, 32'd1);
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, OutValid}, 32'd0);
        check("async_rst_sum",   Sum,               32'd0);
        check("async_rst_carry", {31'b0, CarryOut}, 32'd0);
        check("async_rst_ovf",   {31'b0, Overflow}, 32'd0);
        check("async_rst_zero",  {31'b0, Zero},     32'd0);
        q.delete();
        hold_n = 0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (6) step();
        send(32'h0000_0100, 32'h0000_0023, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
